// File: rtl/dram_capture_writer.sv
// Streams sample lines into a time-stamp-addressed DRAM ring buffer and freezes
// writing once a post-trigger window is complete, pulsing triggering_status.
module dram_capture_writer #(
    parameter int          POST_TRIG = 12,
    parameter logic [24:0] BASE_ADDR = 25'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] sample_data,
    input  logic         sample_valid,
    input  logic         trigger_in,
    input  logic         rearm,
    output logic         DRAM_Write_Enable,
    output logic [24:0]  DRAM_Write_Addr,
    output logic [255:0] DRAM_Write_Data,
    input  logic         DRAM_Write_Ready,
    output logic [15:0]  triggering_time_stamp,
    output logic         triggering_status,
    output logic [15:0]  overflow_count
);

    typedef enum logic [1:0] {ARMED, POST, DRAIN, HOLD} state_t;

    state_t      state;
    logic [15:0] wr_ptr;
    logic [15:0] post_cnt;
    logic        slot_free;
    logic        capturing;

    assign slot_free = !DRAM_Write_Enable || DRAM_Write_Ready;
    // Only ARMED/POST consume samples; the pointer tracks time even for drops.
    assign capturing = sample_valid && (state == ARMED || state == POST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the wide data register is reset too, so a fresh reset shows a clean zero line.
            state                 <= ARMED;
            wr_ptr                <= 16'd0;
            post_cnt              <= 16'd0;
            DRAM_Write_Enable     <= 1'b0;
            DRAM_Write_Addr       <= BASE_ADDR;
            DRAM_Write_Data       <= '0;
            triggering_time_stamp <= 16'd0;
            triggering_status     <= 1'b0;
            overflow_count        <= 16'd0;
        end else begin
            // NOTE: later assignments in this block override these defaults within the same cycle.
            triggering_status <= 1'b0;
            if (slot_free)
                DRAM_Write_Enable <= 1'b0;

            if (capturing) begin
                wr_ptr <= wr_ptr + 16'd1;
                if (slot_free) begin
                    DRAM_Write_Enable <= 1'b1;
                    DRAM_Write_Addr   <= BASE_ADDR + {9'b0, wr_ptr};
                    DRAM_Write_Data   <= sample_data;
                end else if (overflow_count != 16'hFFFF) begin
                    overflow_count <= overflow_count + 16'd1;
                end
            end

            case (state)
                ARMED: begin
                    if (sample_valid && trigger_in) begin
                        triggering_time_stamp <= wr_ptr;
                        post_cnt              <= 16'd1;
                        state                 <= (POST_TRIG <= 1) ? DRAIN : POST;
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        post_cnt <= post_cnt + 16'd1;
                        if (post_cnt + 16'd1 == 16'(POST_TRIG))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Window is in DRAM once the last line has been handed over.
                    if (slot_free) begin
                        state             <= HOLD;
                        triggering_status <= 1'b1;
                    end
                end
                HOLD: begin
                    if (rearm)
                        state <= ARMED;
                end
                default: state <= ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_capture_writer.sv
// Self-checking bench for dram_capture_writer: a vector table for streaming and
// backpressure plus hand-written trigger, wrap, rearm and reset sequences.
module tb_dram_capture_writer;

    localparam logic [24:0] BASE = 25'd0;
    localparam int          PT   = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] sample_data = '0;
    logic         sample_valid = 1'b0;
    logic         trigger_in = 1'b0;
    logic         rearm = 1'b0;
    logic         DRAM_Write_Enable;
    logic [24:0]  DRAM_Write_Addr;
    logic [255:0] DRAM_Write_Data;
    logic         DRAM_Write_Ready = 1'b0;
    logic [15:0]  triggering_time_stamp;
    logic         triggering_status;
    logic [15:0]  overflow_count;

    dram_capture_writer #(.POST_TRIG(PT), .BASE_ADDR(BASE)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .sample_data           (sample_data),
        .sample_valid          (sample_valid),
        .trigger_in            (trigger_in),
        .rearm                 (rearm),
        .DRAM_Write_Enable     (DRAM_Write_Enable),
        .DRAM_Write_Addr       (DRAM_Write_Addr),
        .DRAM_Write_Data       (DRAM_Write_Data),
        .DRAM_Write_Ready      (DRAM_Write_Ready),
        .triggering_time_stamp (triggering_time_stamp),
        .triggering_status     (triggering_status),
        .overflow_count        (overflow_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0]  addr;
        logic [255:0] data;
    } wr_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        push;
        logic        exp_en;
        logic [24:0] exp_addr;
        logic [15:0] exp_d;
        logic [15:0] exp_ovf;
    } vec_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  status_pulses = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] dat(input logic [15:0] p);
        return {8{16'hA5A5, p}};
    endfunction

    function automatic logic [24:0] addr_of(input logic [15:0] p);
        return BASE + {9'b0, p};
    endfunction

    task automatic push(input logic [15:0] p, input logic [255:0] d);
        wr_t w;
        w.addr = addr_of(p);
        w.data = d;
        sb.push_back(w);
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle just after it.
    task automatic step(input logic v, input logic [255:0] d, input logic t,
                        input logic r, input logic ra);
        sample_valid     = v;
        sample_data      = d;
        trigger_in       = t;
        DRAM_Write_Ready = r;
        rearm            = ra;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && triggering_status)
            status_pulses++;
        if (rst && DRAM_Write_Enable && DRAM_Write_Ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h, expected no write", DRAM_Write_Addr);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", 256'(DRAM_Write_Addr), 256'(w.addr));
                check("wr_data", DRAM_Write_Data, w.data);
            end
        end
    end

    vec_t vecs[12];

    initial begin
        logic [15:0] p;

        vecs[0]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 25'd0, 16'h0000, 16'd0};
        vecs[1]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 25'd1, 16'h0001, 16'd0};
        vecs[2]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 25'd2, 16'h0002, 16'd0};
        vecs[3]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 25'd3, 16'h0003, 16'd0};
        vecs[4]  = '{1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 25'd4, 16'h0004, 16'd0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 25'd4, 16'h0004, 16'd0};
        vecs[6]  = '{1'b1, 16'h0055, 1'b1, 1'b1, 1'b1, 25'd5, 16'h0055, 16'd0};
        vecs[7]  = '{1'b1, 16'h0066, 1'b0, 1'b0, 1'b1, 25'd5, 16'h0055, 16'd1};
        vecs[8]  = '{1'b1, 16'h0077, 1'b0, 1'b0, 1'b1, 25'd5, 16'h0055, 16'd2};
        vecs[9]  = '{1'b1, 16'h0088, 1'b0, 1'b0, 1'b1, 25'd5, 16'h0055, 16'd3};
        vecs[10] = '{1'b1, 16'h0099, 1'b1, 1'b1, 1'b1, 25'd9, 16'h0099, 16'd3};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 25'd9, 16'h0099, 16'd3};

        // Reset values
        step(1'b1, dat(16'h1234), 1'b1, 1'b1, 1'b0);
        step(1'b1, dat(16'h1234), 1'b1, 1'b1, 1'b0);
        check("rst_en", 256'(DRAM_Write_Enable), 256'(1'b0));
        check("rst_addr", 256'(DRAM_Write_Addr), 256'(BASE));
        check("rst_data", DRAM_Write_Data, 256'd0);
        check("rst_status", 256'(triggering_status), 256'(1'b0));
        check("rst_stamp", 256'(triggering_time_stamp), 256'd0);
        check("rst_ovf", 256'(overflow_count), 256'd0);
        rst = 1'b1;

        // Streaming and backpressure vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].push)
                push(vecs[i].exp_addr[15:0], 256'(vecs[i].exp_d));
            step(vecs[i].v, 256'(vecs[i].d), 1'b0, vecs[i].rdy, 1'b0);
            check($sformatf("vec%0d_en", i), 256'(DRAM_Write_Enable), 256'(vecs[i].exp_en));
            check($sformatf("vec%0d_addr", i), 256'(DRAM_Write_Addr), 256'(vecs[i].exp_addr));
            check($sformatf("vec%0d_data", i), DRAM_Write_Data, 256'(vecs[i].exp_d));
            check($sformatf("vec%0d_ovf", i), 256'(overflow_count), 256'(vecs[i].exp_ovf));
        end

        // Trigger window at 0x0100
        for (int i = 10; i < 'h100; i++) begin
            push(16'(i), dat(16'(i)));
            step(1'b1, dat(16'(i)), 1'b0, 1'b1, 1'b0);
        end
        push(16'h0100, dat(16'h0100));
        step(1'b1, dat(16'h0100), 1'b1, 1'b1, 1'b0);
        check("trig1_stamp", 256'(triggering_time_stamp), 256'h0100);
        for (int k = 1; k < PT; k++) begin
            p = 16'h0100 + 16'(k);
            push(p, dat(p));
            step(1'b1, dat(p), 1'b1, 1'b1, 1'b0);
            check("trig1_status_low", 256'(triggering_status), 256'(1'b0));
        end
        check("trig1_last_addr", 256'(DRAM_Write_Addr), 256'(addr_of(16'h010B)));
        step(1'b1, dat(16'hDEAD), 1'b0, 1'b1, 1'b0);
        check("trig1_status_pulse", 256'(triggering_status), 256'(1'b1));
        check("trig1_en_off", 256'(DRAM_Write_Enable), 256'(1'b0));
        step(1'b1, dat(16'hDEAD), 1'b1, 1'b1, 1'b0);
        check("trig1_status_end", 256'(triggering_status), 256'(1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, dat(16'hDEAD), 1'b0, 1'b1, 1'b0);
            check("hold_no_write", 256'(DRAM_Write_Enable), 256'(1'b0));
        end

        // Rearm beats a simultaneous trigger; next sample resumes at frozen ptr
        step(1'b1, dat(16'hBEEF), 1'b1, 1'b1, 1'b1);
        check("rearm_no_write", 256'(DRAM_Write_Enable), 256'(1'b0));
        check("rearm_stamp_kept", 256'(triggering_time_stamp), 256'h0100);
        push(16'h010C, dat(16'h010C));
        step(1'b1, dat(16'h010C), 1'b0, 1'b1, 1'b0);
        check("rearm_addr", 256'(DRAM_Write_Addr), 256'(addr_of(16'h010C)));
        check("rearm_en", 256'(DRAM_Write_Enable), 256'(1'b1));

        // Wrap window at 0xFFFA
        for (int i = 'h10D; i <= 'hFFF9; i++) begin
            push(16'(i), dat(16'(i)));
            step(1'b1, dat(16'(i)), 1'b0, 1'b1, 1'b0);
        end
        push(16'hFFFA, dat(16'hFFFA));
        step(1'b1, dat(16'hFFFA), 1'b1, 1'b1, 1'b0);
        check("wrap_stamp", 256'(triggering_time_stamp), 256'hFFFA);
        for (int k = 1; k < PT; k++) begin
            p = 16'hFFFA + 16'(k);
            push(p, dat(p));
            step(1'b1, dat(p), 1'b0, 1'b1, 1'b0);
        end
        check("wrap_last_addr", 256'(DRAM_Write_Addr), 256'(addr_of(16'h0005)));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("wrap_status_pulse", 256'(triggering_status), 256'(1'b1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("wrap_status_end", 256'(triggering_status), 256'(1'b0));

        // Mid-window reset with a write pending
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        push(16'h0006, dat(16'h0006));
        step(1'b1, dat(16'h0006), 1'b1, 1'b1, 1'b0);
        check("mid_addr", 256'(DRAM_Write_Addr), 256'(addr_of(16'h0006)));
        step(1'b1, dat(16'h0007), 1'b0, 1'b0, 1'b0);
        check("mid_ovf", 256'(overflow_count), 256'd4);
        check("mid_pending", 256'(DRAM_Write_Enable), 256'(1'b1));
        rst = 1'b0;
        step(1'b1, dat(16'h0008), 1'b0, 1'b0, 1'b0);
        check("mid_rst_en", 256'(DRAM_Write_Enable), 256'(1'b0));
        check("mid_rst_status", 256'(triggering_status), 256'(1'b0));
        check("mid_rst_ovf", 256'(overflow_count), 256'd0);
        check("mid_rst_stamp", 256'(triggering_time_stamp), 256'd0);
        sb.delete();
        rst = 1'b1;
        push(16'h0000, dat(16'h7777));
        step(1'b1, dat(16'h7777), 1'b0, 1'b1, 1'b0);
        check("post_rst_addr", 256'(DRAM_Write_Addr), 256'(addr_of(16'h0000)));
        check("post_rst_en", 256'(DRAM_Write_Enable), 256'(1'b1));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        check("sb_drained", 256'(sb.size()), 256'd0);
        check("status_pulses", 256'(status_pulses), 256'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_capture_writer.md
# dram_capture_writer

Write-side companion of the UDP readout path in the DarkMatter capture design. Streams 256-bit sample lines into a DRAM ring buffer whose address equals the sample's 16-bit time stamp. On a trigger, it finishes a fixed post-trigger window, then freezes writing. It then issues a one-cycle `triggering_status` pulse with `triggering_time_stamp`, so the DRAM readout controller can fetch the window starting at that address.

## Interface
- `POST_TRIG`, 12: number of lines written starting at the trigger sample, trigger sample included (matches readout of stamp..stamp+11).
- `BASE_ADDR`, 25'd0: DRAM line address of time stamp 0.
- `clk`  in  1  clock; everything on rising edge.
- `rst`  in  1  reset rst, synchronous, active-low.
- `sample_data`  in  256  sample line.
- `sample_valid`  in  1  sample_data present this cycle. One sample per valid cycle, no backpressure to the source.
- `trigger_in`  in  1  sampled only together with `sample_valid`. Marks that sample as the trigger.
- `rearm`  in  1  pulse; releases HOLD.
- `DRAM_Write_Enable`  out  1  write request.
- `DRAM_Write_Addr`  out  25  line address.
- `DRAM_Write_Data`  out  256  line data.
- `DRAM_Write_Ready`  in  1  write accepted when Enable && Ready.
- `triggering_time_stamp`  out  16  stamp of trigger sample.
- `triggering_status`  out  1  one-cycle pulse: window complete in DRAM.
- `overflow_count`  out  16  saturating count of dropped samples.

## Operation
- Internal 16-bit `wr_ptr`: advances by 1 on every `sample_valid` cycle in ARMED/POST, whether the sample is written or dropped, so address always equals time. Wraps 0xFFFF->0x0000.
- Write address: `BASE_ADDR + {9'b0, wr_ptr}`, computed modulo 2^25.
- One-deep output register (Enable/Addr/Data). Slot free when `!DRAM_Write_Enable || DRAM_Write_Ready`.
- Accepted sample: valid && slot free. Load Data=sample_data, Addr=current ptr, Enable=1.
- Valid && slot busy: sample dropped. Output register unchanged. `overflow_count` += 1, saturating at 0xFFFF. Ptr still advances.
- Slot free and no accepted sample: Enable <= 0.
- States:
  - ARMED: write continuously. A valid sample with `trigger_in`=1 does the following:
    - `triggering_time_stamp` <= ptr.
    - `post_cnt` <= 1.
    - Go to POST. The trigger sample itself is written or dropped by the normal rule.
  - POST: each valid sample increments `post_cnt`; `trigger_in` is ignored. The sample taking `post_cnt` to `POST_TRIG` is the last one handled. Then go to DRAIN. With `POST_TRIG`=1, go straight from ARMED to DRAIN.
  - DRAIN: samples ignored. No ptr advance, no writes, no overflow counting. Wait until Enable=0, or Enable && Ready, then go to HOLD and pulse `triggering_status` for exactly 1 cycle on entry.
  - HOLD: samples and trigger ignored, Enable=0, ptr frozen. This protects the window during readout. `rearm`=1 returns to ARMED next cycle. Ptr resumes from its frozen value.
- `rearm` is ignored in ARMED, POST and DRAIN.
- The post window may wrap past 0xFFFF. No special handling; addresses wrap.
- Reset: synchronous. All state is cleared; there is no outstanding write afterwards, and a write in flight is abandoned.

## Timing
- Reset values:
  - DRAM_Write_Enable=0, DRAM_Write_Addr=BASE_ADDR, DRAM_Write_Data=0.
  - triggering_time_stamp=0, triggering_status=0, overflow_count=0.
  - wr_ptr=0, post_cnt=0, state=ARMED.
- Latency: sample accepted in cycle N → Enable/Addr/Data valid from cycle N+1, held stable until Ready.
- Back-to-back: with Ready tied 1, one write per valid cycle, zero bubbles.
- `triggering_status` asserts the cycle after the final write handshake of the window. If the final sample was dropped, it asserts the cycle after DRAIN sees the slot free. `triggering_time_stamp` is stable from trigger acceptance until the next trigger.
- A trigger and `rearm` arriving in the same cycle in HOLD: `rearm` wins, and the trigger is not honored that cycle.

## Test plan
- **Streaming**: reset, Ready=1, 5 valid samples (data = index) → writes to addrs 0..4 with data 0..4, one per cycle starting 1 cycle after the first valid.
- **Trigger window**: ptr at 0x0100, trigger on a sample, POST_TRIG=12 → last write at 0x010B; `triggering_status` one-cycle pulse the cycle after it; stamp=0x0100. Further samples produce no writes until `rearm`.
- **Backpressure/overflow**: Ready=0 for 3 cycles while valid every cycle → the first sample is held stable at its address and the next 3 are dropped. `overflow_count`=3. The next write lands at addr first+4.
- **Wrap**: trigger at ptr 0xFFFA → writes 0xFFFA..0xFFFF then 0x0000..0x0005; stamp=0xFFFA.
- **Rearm**: after HOLD, pulse `rearm` → the next valid sample is written at the frozen ptr value; a new trigger updates the stamp.
- **Mid-window reset**: rst=0 during POST with a write pending → next cycle Enable=0, status=0, ptr=0, state ARMED.
